pc_next_unit: RTL and testbench

//  Registered program-counter generator. Successor to the two-input PC select: holds the PC, advances

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_redirect_arbiter.sv | 30 +++
 rtl/pc_next_unit.sv | 123 ++++++++++++
 tb/tb_pc_next_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

    // Defaults for a 32-bit core that boots from address zero.
    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequencer states, kept as plain constants so older code can compare raw codes.
    typedef logic [1:0] pc_state_t;
    localparam pc_state_t ST_BOOT = 2'd0;
    localparam pc_state_t ST_RUN  = 2'd1;
    localparam pc_state_t ST_HOLD = 2'd2;

    // Mask of the target bits that must be zero for an INC-aligned fetch address.
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return 64'(inc) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority redirect arbiter: the lowest-indexed valid request wins.
module pc_redirect_arbiter #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 2,
    localparam int SRCW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]       req_valid,
    input  logic [NSRC*WIDTH-1:0] req_target,
    output logic                  hit,
    output logic [SRCW-1:0]       idx,
    output logic [WIDTH-1:0]      target
);

    // Scan from the lowest priority upward so the lowest index overwrites last.
    always_comb begin
        hit    = 1'b0;
        idx    = {SRCW{1'b0}};
        target = {WIDTH{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                hit    = 1'b1;
                idx    = SRCW'(i);
                target = req_target[i*WIDTH +: WIDTH];
            end else begin
                hit    = hit;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered PC generator: sequential advance under fetch handshake,
// prioritised redirects, redirect buffering across stalls, alignment flag.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int                WIDTH    = DEFAULT_WIDTH,
    parameter int                NSRC     = 2,
    parameter int                INC      = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    localparam int               SRCW     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  fetch_ready,
    input  logic [NSRC-1:0]       redirect_valid,
    input  logic [NSRC*WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0]      pc_out,
    output logic                  pc_valid,
    output logic                  redirect_pending,
    output logic [SRCW-1:0]       redirect_src,
    output logic                  align_err
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(INC));

    pc_state_t         state_r;
    pc_state_t         state_nxt_s;
    logic [WIDTH-1:0]  pc_r;
    logic              pc_valid_r;
    logic              pend_valid_r;
    logic [WIDTH-1:0]  pend_target_r;
    logic [SRCW-1:0]   pend_src_r;
    logic [SRCW-1:0]   src_r;
    logic              align_err_r;

    logic              arb_hit_s;
    logic [SRCW-1:0]   arb_idx_s;
    logic [WIDTH-1:0]  arb_target_s;
    logic [WIDTH-1:0]  aligned_s;
    logic              misaligned_s;

    pc_redirect_arbiter #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_arb (
        .req_valid  (redirect_valid),
        .req_target (redirect_target),
        .hit        (arb_hit_s),
        .idx        (arb_idx_s),
        .target     (arb_target_s)
    );

    assign aligned_s    = arb_target_s & ~ALIGN_MASK;
    assign misaligned_s = |(arb_target_s & ALIGN_MASK);

    // Next-state decode: stall parks the sequencer in HOLD, otherwise RUN.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = stall ? ST_HOLD : ST_RUN;
            ST_RUN:  state_nxt_s = stall ? ST_HOLD : ST_RUN;
            ST_HOLD: state_nxt_s = stall ? ST_HOLD : ST_RUN;
            default: state_nxt_s = ST_BOOT;
        endcase
    end

    // Sequencer state and the registered pc_valid (low only while booting).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            pc_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_valid_r <= (state_nxt_s != ST_BOOT);
        end
    end

    // PC register, pending-redirect buffer, source index and alignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            pend_valid_r  <= 1'b0;
            pend_target_r <= {WIDTH{1'b0}};
            pend_src_r    <= {SRCW{1'b0}};
            src_r         <= {SRCW{1'b0}};
            align_err_r   <= 1'b0;
        end else begin
            align_err_r <= arb_hit_s & misaligned_s;
            if (stall) begin
                // Frozen: newest winner replaces any older buffered redirect.
                if (arb_hit_s) begin
                    pend_valid_r  <= 1'b1;
                    pend_target_r <= aligned_s;
                    pend_src_r    <= arb_idx_s;
                    src_r         <= arb_idx_s;
                end else begin
                    pend_valid_r  <= pend_valid_r;
                end
            end else if (arb_hit_s) begin
                // A fresh redirect squashes both the buffer and the handshake.
                pc_r         <= aligned_s;
                pend_valid_r <= 1'b0;
                src_r        <= arb_idx_s;
            end else if (pend_valid_r) begin
                pc_r         <= pend_target_r;
                pend_valid_r <= 1'b0;
                src_r        <= pend_src_r;
            end else if (pc_valid_r && fetch_ready) begin
                pc_r <= pc_r + WIDTH'(INC);
            end else begin
                pc_r <= pc_r;
            end
        end
    end

    assign pc_out           = pc_r;
    assign pc_valid         = pc_valid_r;
    assign redirect_pending = pend_valid_r;
    assign redirect_src     = src_r;
    assign align_err        = align_err_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with hand-computed expected values.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic [1:0]  redirect_valid;
    logic [63:0] redirect_target;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        redirect_pending;
    logic [0:0]  redirect_src;
    logic        align_err;

    int n_vec;
    int n_err;

    pc_next_unit #(
        .WIDTH    (32),
        .NSRC     (2),
        .INC      (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .pc_out           (pc_out),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .redirect_src     (redirect_src),
        .align_err        (align_err)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic pend);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, pend});
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        fetch_ready     = 1'b1;
        redirect_valid  = 2'b00;
        redirect_target = 64'd0;
        #2;
        chk("rst.pc",    pc_out, 32'h0);
        chk("rst.valid", {31'd0, pc_valid}, 32'd0);
        chk("rst.pend",  {31'd0, redirect_pending}, 32'd0);
        chk("rst.src",   {31'd0, redirect_src}, 32'd0);
        chk("rst.align", {31'd0, align_err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // 1. boot: RESET_PC shown once with pc_valid low, then sequential fetch
        chk("boot.valid", {31'd0, pc_valid}, 32'd0);
        chk("boot.pc",    pc_out, 32'h0);
        step();
        chk("run0.valid", {31'd0, pc_valid}, 32'd1);
        chk("run0.pc",    pc_out, 32'h0);
        step(); chk("run1.pc", pc_out, 32'h4);
        step(); chk("run2.pc", pc_out, 32'h8);
        step(); chk("run3.pc", pc_out, 32'hC);
        step(); chk("run4.pc", pc_out, 32'h10);

        // 2. simultaneous requests: source 0 wins
        redirect_valid  = 2'b11;
        redirect_target = {32'h200, 32'h100};
        step();
        chk("prio.pc",  pc_out, 32'h100);
        chk("prio.src", {31'd0, redirect_src}, 32'd0);

        // 3. redirect buffered during a 3-cycle stall
        stall           = 1'b1;
        redirect_valid  = 2'b10;
        redirect_target = {32'h300, 32'h0};
        step();
        chk_pc("stall1", 32'h100, 1'b1);
        chk("stall1.src", {31'd0, redirect_src}, 32'd1);
        redirect_valid = 2'b00;
        step(); chk_pc("stall2", 32'h100, 1'b1);
        step(); chk_pc("stall3", 32'h100, 1'b1);
        stall       = 1'b0;
        fetch_ready = 1'b0;
        step(); chk_pc("unstall", 32'h300, 1'b0);
        step(); chk_pc("idle", 32'h300, 1'b0);

        // 4. newest buffered redirect wins; same-cycle redirect beats buffer
        stall           = 1'b1;
        redirect_valid  = 2'b01;
        redirect_target = {32'h0, 32'h400};
        step(); chk_pc("buf400", 32'h300, 1'b1);
        redirect_valid  = 2'b10;
        redirect_target = {32'h500, 32'h0};
        step(); chk_pc("buf500", 32'h300, 1'b1);
        redirect_valid = 2'b00;
        stall          = 1'b0;
        step(); chk_pc("apply500", 32'h500, 1'b0);
        stall           = 1'b1;
        redirect_valid  = 2'b01;
        redirect_target = {32'h0, 32'h700};
        step(); chk_pc("buf700", 32'h500, 1'b1);
        stall           = 1'b0;
        redirect_valid  = 2'b10;
        redirect_target = {32'h600, 32'h0};
        step(); chk_pc("beat600", 32'h600, 1'b0);
        chk("beat600.src", {31'd0, redirect_src}, 32'd1);

        // 5. misaligned target and PC wrap-around
        redirect_valid  = 2'b01;
        redirect_target = {32'h0, 32'h103};
        step();
        chk("mis.pc",    pc_out, 32'h100);
        chk("mis.align", {31'd0, align_err}, 32'd1);
        redirect_valid = 2'b00;
        step();
        chk("mis.align_off", {31'd0, align_err}, 32'd0);
        chk("mis.hold",      pc_out, 32'h100);
        redirect_valid  = 2'b01;
        redirect_target = {32'h0, 32'hFFFF_FFFC};
        step(); chk("top.pc", pc_out, 32'hFFFF_FFFC);
        redirect_valid = 2'b00;
        fetch_ready    = 1'b1;
        step(); chk("wrap.pc", pc_out, 32'h0);
        fetch_ready = 1'b0;

        // 6. asynchronous reset while stalled with a pending redirect
        stall           = 1'b1;
        redirect_valid  = 2'b10;
        redirect_target = {32'h800, 32'h0};
        step(); chk_pc("prerst", 32'h0, 1'b1);
        redirect_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pc",    pc_out, 32'h0);
        chk("arst.valid", {31'd0, pc_valid}, 32'd0);
        chk("arst.pend",  {31'd0, redirect_pending}, 32'd0);
        chk("arst.src",   {31'd0, redirect_src}, 32'd0);
        step();
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        chk("reboot.valid", {31'd1 & 31'd0, pc_valid}, 32'd1);
        chk("reboot.pc",    pc_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
